// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
//   Read-side consumer of the async FIFO, entirely in the read clock domain.
//   Converts the FIFO rd_en/rd_empty/registered rd_data interface into a
//   valid/ready stream. Reads are only issued when the FIFO is non-empty and
//   the internal buffer has room for every read still in flight, so the
//   stream sustains one word per cycle under backpressure.
//
// Ports
//   rd_clk        read-domain clock
//   rd_rst_n      asynchronous active-low reset
//   fifo_rd_en    read request to the FIFO
//   fifo_rd_data  FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_rd_empty FIFO empty flag
//   m_valid       stream word available
//   m_data        stream word (0 while m_valid is low)
//   m_ready       downstream accepts word
//   buf_level     words currently held in the internal buffer
//   xfer_count    count of accepted stream words (wraps)
module fifo_rd_stream_adapter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned BUF_DEPTH = RD_LATENCY + 2,
    localparam int unsigned LVL_WIDTH = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [LVL_WIDTH-1:0]  buf_level,
    output logic [15:0]           xfer_count
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    // One spare bit so buffered + in-flight words never overflow the sum.
    localparam int unsigned OCC_W = LVL_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [LVL_WIDTH-1:0]  buf_count;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [OCC_W-1:0]      inflight;
    logic [OCC_W-1:0]      occupancy;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OCC_W'(rd_pipe[i]);
        end
    end

    // Reserve a buffer slot for every issued read before it returns; this is
    // what makes a tail overrun impossible and keeps m_ready off this path.
    assign occupancy  = OCC_W'(buf_count) + inflight;
    assign fifo_rd_en = rd_rst_n && !fifo_rd_empty && (occupancy < OCC_W'(BUF_DEPTH));

    assign push      = rd_pipe[RD_LATENCY-1];
    assign m_valid   = (buf_count != '0);
    assign pop       = m_valid && m_ready;
    assign m_data    = m_valid ? mem[head] : '0;
    assign buf_level = buf_count;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            head       <= '0;
            tail       <= '0;
            buf_count  <= '0;
            rd_pipe    <= '0;
            xfer_count <= '0;
        end else begin
            // Shift form works for RD_LATENCY == 1 where no slice exists.
            rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(fifo_rd_en);
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head       <= next_ptr(head);
                xfer_count <= xfer_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 1'b1;
                2'b01:   buf_count <= buf_count - 1'b1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Storage carries no reset; head/tail/count define which entries are live.
    always_ff @(posedge rd_clk) begin
        if (push) begin
            mem[tail] <= fifo_rd_data;
        end
    end

    a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        !(push && (buf_count == LVL_WIDTH'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter
//   Two adapter instances: lane 0 with RD_LATENCY=1, lane 1 with RD_LATENCY=3.
//   Only one lane is driven at a time; the idle lane sees an empty FIFO.
//   A FIFO model returns data exactly RD_LATENCY cycles after each read and
//   drives random values on fifo_rd_data otherwise. Expected words are queued
//   when loaded into the FIFO model and popped on each stream handshake.
module tb_fifo_rd_stream_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       fifo_empty_v;
    logic [1:0]       m_ready_v;
    logic [1:0]       rd_en_v;
    logic [1:0]       m_valid_v;
    logic [1:0][7:0]  rd_data_v;
    logic [1:0][7:0]  m_data_v;
    logic [1:0][3:0]  lvl_v;
    logic [1:0][15:0] xfer_v;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [$clog2(LAT + 3) - 1:0] lvl_w;

        fifo_rd_stream_adapter #(
            .DATA_WIDTH (8),
            .RD_LATENCY (LAT)
        ) u_dut (
            .rd_clk        (clk),
            .rd_rst_n      (rst_n),
            .fifo_rd_en    (rd_en_v[g]),
            .fifo_rd_data  (rd_data_v[g]),
            .fifo_rd_empty (fifo_empty_v[g]),
            .m_valid       (m_valid_v[g]),
            .m_data        (m_data_v[g]),
            .m_ready       (m_ready_v[g]),
            .buf_level     (lvl_w),
            .xfer_count    (xfer_v[g])
        );

        assign lvl_v[g] = 4'(lvl_w);
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  pend_val[$];
    int unsigned pend_due[$];

    int unsigned n_en, n_acc, first_en, last_en, first_acc, last_acc;
    bit          prev_v, prev_r;
    logic [7:0]  prev_d;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int unsigned lat_of(input int ln);
        return (ln == 0) ? 1 : 3;
    endfunction

    task automatic load(input logic [7:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic clear_stats();
        n_en = 0; n_acc = 0;
        first_en = 0; last_en = 0; first_acc = 0; last_acc = 0;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    endtask

    // One read-clock cycle: drive inputs at the falling edge, sample 1 time
    // unit later, and model what the DUT will do at the next rising edge.
    task automatic step(input int ln, input bit hold_empty, input bit rdy);
        @(negedge clk);
        cyc++;
        if (pend_due.size() != 0 && pend_due[0] == cyc) begin
            rd_data_v[ln] = pend_val.pop_front();
            void'(pend_due.pop_front());
        end else begin
            rd_data_v[ln] = 8'($urandom);
        end
        fifo_empty_v[ln] = hold_empty || (fifo_q.size() == 0);
        m_ready_v[ln]    = rdy;
        #1;
        if (prev_v && !prev_r) begin
            check_val("hold_valid", m_valid_v[ln], 1);
            check_val("hold_data", m_data_v[ln], prev_d);
        end
        if (!m_valid_v[ln]) check_val("idle_data", m_data_v[ln], 0);
        if (rd_en_v[ln]) begin
            check_val("rd_en_while_empty", fifo_empty_v[ln], 0);
            if (n_en == 0) first_en = cyc;
            last_en = cyc;
            n_en++;
            if (fifo_q.size() != 0) begin
                pend_val.push_back(fifo_q.pop_front());
                pend_due.push_back(cyc + lat_of(ln));
            end
        end
        if (m_valid_v[ln] && rdy) begin
            if (n_acc == 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
            if (exp_q.size() == 0) check_val("sb_underflow", exp_q.size(), 1);
            else check_val("word", m_data_v[ln], exp_q.pop_front());
        end
        prev_v = m_valid_v[ln];
        prev_r = rdy;
        prev_d = m_data_v[ln];
    endtask

    task automatic drain(input int ln, input int unsigned max_cyc);
        int unsigned k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            step(ln, 1'b0, 1'b1);
            k++;
        end
        check_val("drain_done", exp_q.size(), 0);
    endtask

    task automatic check_idle(input int ln);
        check_val("idle_rd_en", rd_en_v[ln], 0);
        check_val("idle_m_valid", m_valid_v[ln], 0);
        check_val("idle_m_data", m_data_v[ln], 0);
        check_val("idle_buf_level", lvl_v[ln], 0);
        check_val("idle_xfer", xfer_v[ln], 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;

        rst_n        = 1'b0;
        fifo_empty_v = '1;
        m_ready_v    = '0;
        rd_data_v    = '0;
        clear_stats();

        // Reset state, then 10 cycles with an empty FIFO.
        repeat (3) @(negedge clk);
        #1;
        check_idle(0);
        check_idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            step(0, 1'b1, 1'b1);
            check_idle(0);
        end

        // Full-rate streaming, RD_LATENCY=1.
        clear_stats();
        for (int i = 0; i < 8; i++) load(8'(8'h10 + i));
        drain(0, 40);
        step(0, 1'b0, 1'b1);
        check_val("t2_en_pulses", n_en, 8);
        check_val("t2_en_span", last_en - first_en, 7);
        check_val("t2_first_latency", first_acc - first_en, 2);
        check_val("t2_acc_span", last_acc - first_acc, 7);
        check_val("t2_xfer", xfer_v[0], 8);

        // Backpressure: buffer fills to 3, then drains without gaps.
        clear_stats();
        for (int i = 0; i < 8; i++) load(8'(8'h10 + i));
        repeat (10) step(0, 1'b0, 1'b0);
        check_val("t3_en_pulses", n_en, 3);
        check_val("t3_rd_en_stalled", rd_en_v[0], 0);
        check_val("t3_buf_level", lvl_v[0], 3);
        check_val("t3_head_data", m_data_v[0], 8'h10);
        clear_stats();
        drain(0, 40);
        step(0, 1'b0, 1'b1);
        check_val("t3_resume_en", n_en, 5);
        check_val("t3_acc_count", n_acc, 8);
        check_val("t3_acc_span", last_acc - first_acc, 7);
        check_val("t3_xfer", xfer_v[0], 16);

        // RD_LATENCY=3: full-rate latency, then random empty and backpressure.
        clear_stats();
        for (int i = 0; i < 12; i++) load(8'(8'hA0 + i));
        drain(1, 60);
        step(1, 1'b0, 1'b1);
        check_val("t4_first_latency", first_acc - first_en, 4);
        check_val("t4_acc_span", last_acc - first_acc, 11);
        check_val("t4_en_pulses", n_en, 12);
        clear_stats();
        for (int i = 0; i < 40; i++) load(8'($urandom));
        k = 0;
        while (exp_q.size() != 0 && k < 600) begin
            step(1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
            k++;
        end
        check_val("t4_drain", exp_q.size(), 0);
        step(1, 1'b0, 1'b1);
        check_val("t4_xfer", xfer_v[1], 52);
        check_val("t4_buf_level", lvl_v[1], 0);
        fifo_empty_v[1] = 1'b1;
        m_ready_v[1]    = 1'b0;

        // Reset with two buffered words and one read in flight.
        clear_stats();
        for (int i = 0; i < 3; i++) load(8'(8'h51 + i));
        k = 0;
        while (lvl_v[0] != 4'd2 && k < 20) begin
            step(0, 1'b0, 1'b0);
            k++;
        end
        check_val("t5_pre_level", lvl_v[0], 2);
        check_val("t5_pre_pulses", n_en, 3);
        #1 rst_n = 1'b0;
        #1;
        check_val("t5_async_valid", m_valid_v[0], 0);
        check_val("t5_async_level", lvl_v[0], 0);
        check_val("t5_async_xfer", xfer_v[0], 0);
        check_val("t5_async_rd_en", rd_en_v[0], 0);
        #1 rst_n = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        pend_val.delete();
        pend_due.delete();
        clear_stats();
        repeat (5) begin
            step(0, 1'b1, 1'b0);
            check_idle(0);
        end

        // xfer_count wrap.
        clear_stats();
        for (int i = 0; i < 65535; i++) load(8'(i));
        drain(0, 65600);
        step(0, 1'b0, 1'b1);
        check_val("t6_xfer_ffff", xfer_v[0], 16'hFFFF);
        load(8'hEE);
        drain(0, 10);
        step(0, 1'b0, 1'b1);
        check_val("t6_xfer_wrap", xfer_v[0], 16'h0000);
        load(8'h77);
        drain(0, 10);
        step(0, 1'b0, 1'b1);
        check_val("t6_xfer_one", xfer_v[0], 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
